// File: rtl/cdb_broadcaster_pkg.sv
// cdb_broadcaster_pkg: shared widths and tag constants for the common-data-bus broadcaster
package cdb_broadcaster_pkg;
  localparam int LABEL_W = 5;
  localparam int DATA_W = 32;
  localparam int NULL_TAG = 0;
  localparam int Q_ADD = 1;
  localparam int Q_MUL = 2;
  localparam int Q_LOAD = 3;
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result buffer; caller guarantees no push when full and no pop when empty
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rdPtr];
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= wdata;
endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers functional-unit results and broadcasts one per cycle, round-robin, on BCEN/BClabel/BCdata
module cdb_broadcaster #(
  parameter int N_SRC = 3,
  parameter int DEPTH = 2,
  parameter int LABEL_W = cdb_broadcaster_pkg::LABEL_W,
  parameter int DATA_W = cdb_broadcaster_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*LABEL_W-1:0] src_label,
  input  logic [N_SRC*DATA_W-1:0]  src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic                     BCEN,
  output logic [LABEL_W-1:0]       BClabel,
  output logic [DATA_W-1:0]        BCdata,
  output logic                     err_zero_label
);
  import cdb_broadcaster_pkg::*;
  localparam int PW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam int EW = LABEL_W + DATA_W;
  logic [EW-1:0] head [N_SRC];
  logic [N_SRC-1:0] full, empty, push, pop, nullPush;
  logic [PW-1:0] rrPtr, win, cand;
  logic hasWin;
  for (genvar g = 0; g < N_SRC; g++) begin : gSrc
    assign nullPush[g] = src_valid[g] && !full[g] && src_label[g*LABEL_W +: LABEL_W] == LABEL_W'(NULL_TAG);
    assign push[g] = src_valid[g] && !full[g] && !nullPush[g];
    assign pop[g] = hasWin && win == PW'(g);
    cdb_src_fifo #(.DEPTH(DEPTH), .W(EW)) uFifo (
      .clk(clk),
      .nRST(nRST),
      .push(push[g]),
      .pop(pop[g]),
      .wdata({src_label[g*LABEL_W +: LABEL_W], src_data[g*DATA_W +: DATA_W]}),
      .rdata(head[g]),
      .full(full[g]),
      .empty(empty[g])
    );
  end
  assign src_ready = ~full;
  // scan downward so the candidate nearest rrPtr is written last and wins
  always_comb begin
    hasWin = 1'b0;
    win = '0;
    cand = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = PW'((int'(rrPtr) + k) % N_SRC);
      if (!empty[cand]) begin
        hasWin = 1'b1;
        win = cand;
      end
    end
  end
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      BCEN <= 1'b0;
      BClabel <= '0;
      BCdata <= '0;
      rrPtr <= '0;
      err_zero_label <= 1'b0;
    end else begin
      BCEN <= hasWin;
      {BClabel, BCdata} <= hasWin ? head[win] : '0;
      if (hasWin) rrPtr <= PW'((int'(win) + 1) % N_SRC);
      if (|nullPush) err_zero_label <= 1'b1;
    end
endmodule
